// File: rtl/adc_serial_cfg.sv
// Serial configuration master: shifts a 24-bit address/data word to one ADC (or all twelve), or issues a hardware-reset pulse.
// Latency: outputs respond 1 cycle after START/HW_RST_REQ; a write takes 49*CLK_DIV cycles, with DONE in the cycle after that.
// Backpressure: BUSY is high while a write or reset pulse is in progress; START/HW_RST_REQ during BUSY are dropped, not queued.
module adc_serial_cfg #(
  parameter int CLK_DIV   = 4,
  parameter int RST_PULSE = 16
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        start,
  input  logic [3:0]  adc_sel,
  input  logic [23:0] wdata,
  input  logic        hw_rst_req,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [11:0] adc_cs,
  output logic        adc_rst,
  output logic        adc_sclk,
  output logic        adc_sdata
);

  // One phase counter serves both the SCLK half-period and the reset pulse, so size it for the longer one.
  localparam int PMAX = (CLK_DIV > RST_PULSE) ? CLK_DIV : RST_PULSE;
  localparam int PW   = $clog2(PMAX + 1);
  localparam logic [PW-1:0] DIV_LD = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] RST_LD = PW'(RST_PULSE - 1);
  localparam logic [PW-1:0] ONE    = PW'(1);

  typedef enum logic [2:0] {
    IDLE,
    RSTP,
    SETUP,
    SCLK_HI,
    SCLK_LO,
    HOLD
  } state_t;

  state_t         state;
  logic [PW-1:0]  phase_cnt;
  logic [4:0]     bit_cnt;
  logic [23:0]    shreg;
  logic           sel_legal;
  logic [11:0]    sel_cs;
  logic           phase_end;

  // Decode the requested target: 0-11 one-hot, 15 broadcast, 12-14 rejected.
  always_comb begin
    sel_legal = (adc_sel < 4'd12) || (adc_sel == 4'd15);
    sel_cs    = (adc_sel == 4'd15) ? 12'hFFF : (12'h001 << adc_sel);
    phase_end = (phase_cnt == '0);
  end

  // Sequencer: every output is registered and updated on the edge that enters its phase.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state     <= IDLE;
      phase_cnt <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      adc_cs    <= '0;
      adc_rst   <= 1'b0;
      adc_sclk  <= 1'b0;
      adc_sdata <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          // Hardware reset wins over a write presented on the same edge.
          if (hw_rst_req) begin
            state     <= RSTP;
            phase_cnt <= RST_LD;
            adc_rst   <= 1'b1;
            busy      <= 1'b1;
          end else if (start) begin
            if (sel_legal) begin
              state     <= SETUP;
              phase_cnt <= DIV_LD;
              bit_cnt   <= '0;
              shreg     <= wdata;
              adc_cs    <= sel_cs;
              adc_sdata <= wdata[23];
              busy      <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RSTP: begin
          if (phase_end) begin
            state   <= IDLE;
            adc_rst <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt - ONE;
          end
        end
        SETUP: begin
          if (phase_end) begin
            state     <= SCLK_HI;
            phase_cnt <= DIV_LD;
            adc_sclk  <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt - ONE;
          end
        end
        SCLK_HI: begin
          if (phase_end) begin
            phase_cnt <= DIV_LD;
            adc_sclk  <= 1'b0;
            // After the last bit keep SDATA on bit 0 through the hold phase.
            if (bit_cnt == 5'd23) begin
              state <= HOLD;
            end else begin
              state     <= SCLK_LO;
              bit_cnt   <= bit_cnt + 5'd1;
              shreg     <= {shreg[22:0], 1'b0};
              adc_sdata <= shreg[22];
            end
          end else begin
            phase_cnt <= phase_cnt - ONE;
          end
        end
        SCLK_LO: begin
          if (phase_end) begin
            state     <= SCLK_HI;
            phase_cnt <= DIV_LD;
            adc_sclk  <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt - ONE;
          end
        end
        HOLD: begin
          if (phase_end) begin
            state     <= IDLE;
            adc_cs    <= '0;
            adc_sdata <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt - ONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serial_cfg.sv
// Bench for adc_serial_cfg: directed and random writes, illegal selects, reset pulses, abort and back-to-back.
// Expected output levels are computed per cycle from the phase arithmetic of a write (49 half-periods).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_adc_serial_cfg;

  localparam int CLK_DIV   = 4;
  localparam int RST_PULSE = 16;
  localparam int WR_LEN    = 49 * CLK_DIV;

  logic        clk;
  logic        rst_b;
  logic        start;
  logic [3:0]  adc_sel;
  logic [23:0] wdata;
  logic        hw_rst_req;
  logic        busy;
  logic        done;
  logic        err;
  logic [11:0] adc_cs;
  logic        adc_rst;
  logic        adc_sclk;
  logic        adc_sdata;

  logic [17:0] obs;
  int          n_assert;
  int          n_fail;

  localparam logic [17:0] ZERO_V = 18'h0;
  localparam logic [17:0] DONE_V = {1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0};
  localparam logic [17:0] ERR_V  = {1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0};
  localparam logic [17:0] RSTP_V = {1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0};

  adc_serial_cfg #(
    .CLK_DIV  (CLK_DIV),
    .RST_PULSE(RST_PULSE)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .adc_sel   (adc_sel),
    .wdata     (wdata),
    .hw_rst_req(hw_rst_req),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .adc_cs    (adc_cs),
    .adc_rst   (adc_rst),
    .adc_sclk  (adc_sclk),
    .adc_sdata (adc_sdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {busy, done, err, adc_cs, adc_rst, adc_sclk, adc_sdata};

  // Expected {busy,done,err,cs,rst,sclk,sdata} in cycle t after the accepting edge of a write.
  function automatic logic [17:0] exp_write(input int t, input logic [11:0] cs, input logic [23:0] w);
    int p;
    int j;
    logic [17:0] e;
    if (t <= WR_LEN) begin
      p = (t - 1) / CLK_DIV;   // half-period index: 0 setup, odd = SCLK high, 48 = hold
      j = p / 2;               // bits already shifted out
      if (j > 23) j = 23;
      e = {1'b1, 1'b0, 1'b0, cs, 1'b0, (p % 2 == 1), w[23 - j]};
    end else begin
      e = DONE_V;
    end
    return e;
  endfunction

  function automatic logic [11:0] cs_of(input logic [3:0] sel);
    return (sel == 4'd15) ? 12'hFFF : (12'h001 << sel);
  endfunction

  function automatic logic [3:0] rand_legal_sel();
    int r;
    r = $urandom_range(12, 0);
    return (r == 12) ? 4'd15 : 4'(r);
  endfunction

  task automatic chk(input string tag, input logic [17:0] e);
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic chk_val(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Issue a write and check every cycle; stop_t>0 ends early after checking cycle stop_t.
  task automatic do_write(input logic [3:0] sel, input logic [23:0] w, input bit noise, input int stop_t);
    logic [11:0] cs;
    logic [23:0] got;
    logic        prev;
    int          rises;
    cs    = cs_of(sel);
    got   = '0;
    prev  = 1'b0;
    rises = 0;
    start   = 1'b1;
    adc_sel = sel;
    wdata   = w;
    for (int t = 1; t <= WR_LEN + 1; t++) begin
      @(negedge clk);
      if (t == 1) start = 1'b0;
      chk($sformatf("write sel%0d t%0d", sel, t), exp_write(t, cs, w));
      if (adc_sclk && !prev) begin
        rises++;
        got = {got[22:0], adc_sdata};
      end
      prev = adc_sclk;
      if (noise) begin
        if (t < WR_LEN) begin
          start      = 1'($urandom);
          hw_rst_req = 1'($urandom);
          adc_sel    = 4'($urandom);
          wdata      = 24'($urandom);
        end else begin
          start      = 1'b0;
          hw_rst_req = 1'b0;
        end
      end
      if (t == stop_t) return;
    end
    chk_val($sformatf("sclk rises sel%0d", sel), 32'(rises), 32'd24);
    chk_val($sformatf("bits at rises sel%0d", sel), {8'h0, got}, {8'h0, w});
  endtask

  task automatic do_illegal(input logic [3:0] sel);
    start   = 1'b1;
    adc_sel = sel;
    wdata   = 24'($urandom);
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("illegal sel%0d err", sel), ERR_V);
    for (int t = 2; t <= 4; t++) begin
      @(negedge clk);
      chk($sformatf("illegal sel%0d quiet t%0d", sel, t), ZERO_V);
    end
  endtask

  // Reset pulse requested together with a legal START; reset must win and later STARTs are dropped.
  task automatic do_rst_pulse();
    hw_rst_req = 1'b1;
    start      = 1'b1;
    adc_sel    = 4'd2;
    wdata      = 24'h123456;
    for (int t = 1; t <= RST_PULSE + 1; t++) begin
      @(negedge clk);
      chk($sformatf("rst pulse t%0d", t), (t <= RST_PULSE) ? RSTP_V : DONE_V);
      if (t < RST_PULSE) begin
        start      = 1'($urandom);
        hw_rst_req = 1'($urandom);
      end else begin
        start      = 1'b0;
        hw_rst_req = 1'b0;
      end
    end
    @(negedge clk);
    chk("rst pulse after", ZERO_V);
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    rst_b      = 1'b0;
    start      = 1'b1;
    hw_rst_req = 1'b1;
    adc_sel    = 4'd0;
    wdata      = '0;
    repeat (2) @(negedge clk);
    chk("in reset", ZERO_V);
    @(negedge clk);
    chk("in reset 2", ZERO_V);
    start      = 1'b0;
    hw_rst_req = 1'b0;
    rst_b      = 1'b1;
    @(negedge clk);
    chk("idle after reset", ZERO_V);

    do_write(4'd3, 24'h42A5C3, 1'b0, 0);
    @(negedge clk);
    chk("idle after single", ZERO_V);
    do_write(4'd15, 24'h0A0001, 1'b0, 0);
    @(negedge clk);
    chk("idle after bcast", ZERO_V);

    do_illegal(4'd13);
    do_illegal(4'd12);
    do_illegal(4'd14);

    do_rst_pulse();

    // Abort in the cycle of the 10th SCLK rise, then confirm silence and a clean fresh write.
    do_write(4'd5, 24'($urandom), 1'b0, 1 + 19 * CLK_DIV);
    rst_b = 1'b0;
    @(negedge clk);
    chk("abort next cycle", ZERO_V);
    rst_b = 1'b1;
    for (int t = 0; t < 2 * CLK_DIV + 4; t++) begin
      @(negedge clk);
      chk($sformatf("abort quiet %0d", t), ZERO_V);
    end
    do_write(4'd7, 24'($urandom), 1'b0, 0);

    // Back-to-back: second START in the DONE cycle, inputs scrambled during the transfer.
    do_write(rand_legal_sel(), 24'($urandom), 1'b0, 0);
    do_write(4'd11, 24'hFFFFFF, 1'b1, 0);
    @(negedge clk);
    chk("idle after b2b", ZERO_V);

    for (int i = 0; i < 4; i++) begin
      do_write(rand_legal_sel(), 24'($urandom), 1'b1, 0);
    end
    @(negedge clk);
    chk("final idle", ZERO_V);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
